// File: rtl/pipe_scheduler_pkg.sv
// Shared types and constants for the pipe scheduler: FSM encoding,
// default scroll divider, pattern-index sizing and the LFSR step function.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    LOST = 2'b10
  } state_t;

  localparam int unsigned DEF_TICK_DIV = 2560;
  localparam int unsigned PATTERNS     = 16;
  localparam int unsigned SEL_W        = $clog2(PATTERNS);
  localparam int unsigned SCORE_W      = 8;

  // Fibonacci form, taps 16,14,13,11 mapped onto bits 0,2,3,5 (right shift).
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [SEL_W-1:0] pattern_of(input logic [15:0] v);
    return v[SEL_W-1:0];
  endfunction

endpackage

// File: rtl/pipe_scheduler_if.sv
// Handshake bundle between the game logic (master) and the scheduler (slave).
interface pipe_scheduler_if;
  import pipe_pkg::*;

  logic               start;
  logic               collision;
  logic               step;
  logic               insert_pipe;
  logic [SEL_W-1:0]   sel;
  logic               loss;
  logic [SCORE_W-1:0] score;
  logic [1:0]         state;

  modport master (
    output start, collision,
    input  step, insert_pipe, sel, loss, score, state
  );

  modport slave (
    input  start, collision,
    output step, insert_pipe, sel, loss, score, state
  );

endinterface

// File: rtl/pipe_scheduler_lfsr16.sv
// Free-running 16-bit pattern LFSR; reloads the seed if it ever reads zero.
module lfsr16
  import pipe_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = lfsr_next(q_q);
    if (q_q == '0) q_d = seed;
  end

  always_ff @(posedge clock) begin
    if (reset) q_q <= seed;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_scheduler.sv
// Playfield scroll scheduler: paces scroll steps, chooses pipe/blank columns,
// tracks pipes passing the bird for scoring, and runs the IDLE/PLAY/LOST FSM.
module pipe_scheduler
  import pipe_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned GAP_COLS  = 3,
  parameter int unsigned BIRD_DIST = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  pipe_scheduler_if.slave   bus
);

  localparam int unsigned TICK_W = 12;
  localparam int unsigned COL_W  = 4;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(GAP_COLS);

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [BIRD_DIST-1:0] track_q, track_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 step_q, step_d;
  logic                 ins_q, ins_d;

  logic [15:0]          lfsr;
  logic                 pipe_now;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  assign pipe_now = (col_q == COL_LAST);

  // The step decision is taken on the edge that ends the tick_cnt==TICK_DIV-1
  // cycle and registered, so a coincident collision can still cancel it
  // without any input reaching an output combinationally.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    col_d   = col_q;
    track_d = track_q;
    score_d = score_q;
    sel_d   = sel_q;
    step_d  = 1'b0;
    ins_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = PLAY;
          tick_d  = '0;
          col_d   = '0;
          track_d = '0;
          score_d = '0;
        end
      end

      PLAY: begin
        if (bus.collision) begin
          state_d = LOST;
        end else if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          step_d  = 1'b1;
          ins_d   = pipe_now;
          track_d = BIRD_DIST'({track_q, pipe_now});
          if (pipe_now) begin
            sel_d = pattern_of(lfsr);
            col_d = '0;
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (track_q[BIRD_DIST-1] && (score_q != '1)) begin
            score_d = score_q + SCORE_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      LOST: begin
        if (bus.start) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      col_q   <= '0;
      track_q <= '0;
      score_q <= '0;
      sel_q   <= '0;
      step_q  <= 1'b0;
      ins_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      col_q   <= col_d;
      track_q <= track_d;
      score_q <= score_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      ins_q   <= ins_d;
    end
  end

  assign bus.step        = step_q;
  assign bus.insert_pipe = ins_q;
  assign bus.sel         = sel_q;
  assign bus.loss        = (state_q == LOST);
  assign bus.score       = score_q;
  assign bus.state       = state_q;

endmodule
